// File: rtl/connect4_pkg.sv
// Definitions shared by the Connect-4 SoC: bus slot selectors, mailbox FSM
// states and status-word bit positions.
package connect4_pkg;

  localparam logic [2:0] SEL_DMEM     = 3'd0;
  localparam logic [2:0] SEL_KEY      = 3'd1;
  localparam logic [2:0] SEL_SWITCH   = 3'd2;
  localparam logic [2:0] SEL_NN_START = 3'd3;
  localparam logic [2:0] SEL_NN_READ  = 3'd4;
  localparam logic [2:0] SEL_VGA      = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } nn_state_t;

  localparam int BIT_BUSY  = 31;
  localparam int BIT_VALID = 30;
  localparam int BIT_TOUT  = 29;
  localparam int BIT_ERR   = 28;
  localparam int BIT_OVR   = 27;

  // Column reported when the accelerator never answers.
  localparam logic [2:0] COL_TIMEOUT = 3'd7;

endpackage

// File: rtl/nn_timeout_timer.sv
// Watchdog for the evaluator: counts WAIT cycles and flags the last one
// (count == TIMEOUT_CYCLES-1) so the mailbox can abandon the evaluation.
module nn_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  // Saturate at LAST so a caller that lingers cannot wrap the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nn_mailbox.sv
// CPU <-> NN move-evaluator mailbox: start slot launches an evaluation, read
// slot returns busy/valid/tout/err/overrun + column with read-to-clear.
module nn_mailbox
  import connect4_pkg::*;
#(
  parameter int COLS           = 7,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  mem_selector,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        nn_start,
  output logic [7:0]  nn_arg,
  input  logic        nn_done,
  input  logic [2:0]  nn_col
);

  nn_state_t  state_q, state_d;
  logic [7:0] arg_q, arg_d;
  logic [2:0] col_q, col_d;
  logic       valid_q, valid_d;
  logic       tout_q, tout_d;
  logic       err_q, err_d;
  logic       ovr_q, ovr_d;

  logic start_wr, read_rd, accept, expired, busy;
  logic unused_wdata;

  assign unused_wdata = ^mem_wdata[31:8];
  assign start_wr     = mem_we && (mem_selector == SEL_NN_START);
  assign read_rd      = mem_re && (mem_selector == SEL_NN_READ);
  assign accept       = start_wr && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  nn_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timer (
    .clock   (clock),
    .resetn  (resetn),
    .clr     (state_q == ST_LAUNCH),
    .en      (state_q == ST_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_wr) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (nn_done || expired) state_d = ST_DONE;
      ST_DONE:   if (start_wr) state_d = ST_LAUNCH;
                 else if (read_rd) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Result/flag registers. A start in DONE beats a same-cycle read.
  always_comb begin
    arg_d   = arg_q;
    col_d   = col_q;
    valid_d = valid_q;
    tout_d  = tout_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    if (accept) begin
      arg_d   = mem_wdata[7:0];
      valid_d = 1'b0;
      tout_d  = 1'b0;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
    end else if (start_wr) begin
      ovr_d = 1'b1;
    end
    if (state_q == ST_WAIT) begin
      if (nn_done) begin
        col_d   = nn_col;
        err_d   = (int'(nn_col) >= COLS);
        valid_d = 1'b1;
      end else if (expired) begin
        col_d   = COL_TIMEOUT;
        tout_d  = 1'b1;
        valid_d = 1'b1;
      end
    end
    if ((state_q == ST_DONE) && !start_wr && read_rd) valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      arg_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      tout_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      arg_q   <= arg_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    nn_start        = (state_q == ST_LAUNCH);
    busy            = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    nn_arg          = arg_q;
    rdata           = '0;
    rdata[BIT_BUSY]  = busy;
    rdata[BIT_VALID] = valid_q;
    rdata[BIT_TOUT]  = tout_q;
    rdata[BIT_ERR]   = err_q;
    rdata[BIT_OVR]   = ovr_q;
    rdata[2:0]       = col_q;
  end

endmodule

// File: tb/tb_nn_mailbox.sv
// Bench for nn_mailbox: directed vector table, hand-written timeout / reset
// sequences, then random traffic against a transaction-level model.
module tb_nn_mailbox;

  localparam int T = 8;

  logic        clock = 1'b0;
  logic        resetn;
  logic [2:0]  mem_selector;
  logic        mem_we, mem_re;
  logic [31:0] mem_wdata, rdata;
  logic        nn_start;
  logic [7:0]  nn_arg;
  logic        nn_done;
  logic [2:0]  nn_col;

  always #5 clock = ~clock;

  nn_mailbox #(.COLS(7), .TIMEOUT_CYCLES(T), .TO_W(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .mem_selector (mem_selector),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_wdata    (mem_wdata),
    .rdata        (rdata),
    .nn_start     (nn_start),
    .nn_arg       (nn_arg),
    .nn_done      (nn_done),
    .nn_col       (nn_col)
  );

  int total = 0;
  int bad   = 0;

  // Model: m_age = -1 when not busy, 0 in the launch cycle, k = k-th wait cycle.
  int       m_age;
  bit       m_valid, m_tout, m_err, m_ovr;
  bit [2:0] m_col;
  bit [7:0] m_arg;

  logic [31:0] obs_rd;
  logic        obs_st;
  logic [7:0]  obs_arg;

  typedef struct {
    logic        we, re;
    logic [2:0]  sel;
    logic [31:0] wd;
    logic        dn;
    logic [2:0]  c;
    logic [31:0] e_rd;
    logic        e_st;
    logic [7:0]  e_arg;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [31:0] m_rdata();
    return {(m_age >= 0), m_valid, m_tout, m_err, m_ovr, 24'b0, m_col};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_age = -1; m_valid = 0; m_tout = 0; m_err = 0; m_ovr = 0; m_col = 0; m_arg = 0;
  endtask

  task automatic model_step(input logic we, input logic re, input logic [2:0] sel,
                            input logic [31:0] wd, input logic dn, input logic [2:0] c);
    bit start, rd;
    start = we && (sel == 3'd3);
    rd    = re && (sel == 3'd4);
    if (m_age == 0) begin
      if (start) m_ovr = 1;
      m_age = 1;
    end else if (m_age > 0) begin
      if (start) m_ovr = 1;
      if (dn) begin
        m_col = c; m_err = (c >= 3'd7); m_valid = 1; m_age = -1;
      end else if (m_age == T) begin
        m_col = 3'd7; m_tout = 1; m_valid = 1; m_age = -1;
      end else begin
        m_age++;
      end
    end else begin
      if (start) begin
        m_arg = wd[7:0]; m_valid = 0; m_tout = 0; m_err = 0; m_ovr = 0; m_age = 0;
      end else if (rd) begin
        m_valid = 0;
      end
    end
  endtask

  // One clock: drive inputs, compare against the model mid-cycle, advance both.
  task automatic cycle(input logic we, input logic re, input logic [2:0] sel,
                       input logic [31:0] wd, input logic dn, input logic [2:0] c);
    mem_we = we; mem_re = re; mem_selector = sel; mem_wdata = wd; nn_done = dn; nn_col = c;
    @(negedge clock);
    obs_rd = rdata; obs_st = nn_start; obs_arg = nn_arg;
    chk("model rdata", obs_rd, m_rdata());
    chk("model nn_start", 32'(obs_st), 32'(m_age == 0));
    chk("model nn_arg", 32'(obs_arg), 32'(m_arg));
    @(posedge clock);
    model_step(we, re, sel, wd, dn, c);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 3'd0, 32'h0, 0, 3'd0);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h0000_0000, 0, 8'h00};
    tbl[1]  = '{1, 0, 3'd3, 32'h02,  0, 3'd0, 32'h0000_0000, 0, 8'h00};
    tbl[2]  = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h8000_0000, 1, 8'h02};
    tbl[3]  = '{0, 0, 3'd0, 32'h0,   1, 3'd4, 32'h8000_0000, 0, 8'h02};
    tbl[4]  = '{0, 1, 3'd4, 32'h0,   0, 3'd0, 32'h4000_0004, 0, 8'h02};
    tbl[5]  = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h0000_0004, 0, 8'h02};
    tbl[6]  = '{1, 0, 3'd3, 32'h105, 0, 3'd0, 32'h0000_0004, 0, 8'h02};
    tbl[7]  = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h8000_0004, 1, 8'h05};
    tbl[8]  = '{1, 0, 3'd3, 32'h09,  0, 3'd0, 32'h8000_0004, 0, 8'h05};
    tbl[9]  = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h8800_0004, 0, 8'h05};
    tbl[10] = '{0, 0, 3'd0, 32'h0,   1, 3'd6, 32'h8800_0004, 0, 8'h05};
    tbl[11] = '{1, 0, 3'd3, 32'h0A,  0, 3'd0, 32'h4800_0006, 0, 8'h05};
    tbl[12] = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h8000_0006, 1, 8'h0A};
    tbl[13] = '{0, 0, 3'd0, 32'h0,   1, 3'd7, 32'h8000_0006, 0, 8'h0A};
    tbl[14] = '{0, 1, 3'd4, 32'h0,   0, 3'd0, 32'h5000_0007, 0, 8'h0A};
    tbl[15] = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h1000_0007, 0, 8'h0A};
    tbl[16] = '{0, 1, 3'd4, 32'h0,   1, 3'd2, 32'h1000_0007, 0, 8'h0A};
    tbl[17] = '{0, 0, 3'd0, 32'h0,   0, 3'd0, 32'h1000_0007, 0, 8'h0A};

    resetn = 0; mem_we = 0; mem_re = 0; mem_selector = 0; mem_wdata = 0; nn_done = 0; nn_col = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset rdata", rdata, 32'h0);
    chk("reset nn_start", 32'(nn_start), 32'h0);
    chk("reset nn_arg", 32'(nn_arg), 32'h0);
    resetn = 1;

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].we, tbl[i].re, tbl[i].sel, tbl[i].wd, tbl[i].dn, tbl[i].c);
      chk($sformatf("vec%0d rdata", i), obs_rd, tbl[i].e_rd);
      chk($sformatf("vec%0d nn_start", i), 32'(obs_st), 32'(tbl[i].e_st));
      chk($sformatf("vec%0d nn_arg", i), 32'(obs_arg), 32'(tbl[i].e_arg));
    end

    // Timeout: exactly T wait cycles stay busy, then col 7 with tout.
    cycle(1, 0, 3'd3, 32'h03, 0, 3'd0);
    idle();
    for (int i = 0; i < T; i++) begin
      idle();
      chk($sformatf("timeout wait%0d busy", i), 32'(obs_rd[31]), 32'h1);
    end
    idle();
    chk("timeout result", obs_rd, 32'h6000_0007);

    // Done on the last timeout cycle wins over expiry.
    cycle(1, 0, 3'd3, 32'h04, 0, 3'd0);
    idle();
    for (int i = 0; i < T - 1; i++) idle();
    cycle(0, 0, 3'd0, 32'h0, 1, 3'd3);
    idle();
    chk("done at expiry", obs_rd, 32'h4000_0003);

    // Reset mid-evaluation, then a stray done is ignored.
    cycle(1, 0, 3'd3, 32'h33, 0, 3'd0);
    idle();
    idle();
    resetn = 0;
    #1;
    chk("midreset rdata", rdata, 32'h0);
    chk("midreset nn_start", 32'(nn_start), 32'h0);
    chk("midreset nn_arg", 32'(nn_arg), 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    resetn = 1;
    cycle(0, 0, 3'd0, 32'h0, 1, 3'd5);
    idle();
    chk("post-reset done ignored", obs_rd, 32'h0);

    for (int i = 0; i < 500; i++) begin
      logic       we, re, dn;
      logic [2:0] sel, c;
      we  = ($urandom % 6) == 0;
      re  = ($urandom % 3) == 0;
      sel = ($urandom % 2) != 0 ? 3'(3 + $urandom % 2) : 3'($urandom % 8);
      dn  = ($urandom % 5) == 0;
      c   = 3'($urandom % 8);
      cycle(we, re, sel, $urandom, dn, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
